// File: rtl/clk_freq_encoder_if.sv
// Measurement bus for clk_freq_encoder: control/clock-under-test in, encoded result out.
`timescale 1ns/1ps
interface clk_freq_encoder_if #(
    parameter int CNT_W = 12
) ();
    logic             enable;
    logic             meas_clk_in;
    logic [1:0]       clk_freq_enc;
    logic [3:0]       clock_frequency_enc;
    logic [CNT_W-1:0] edge_count;
    logic             meas_valid;
    logic             locked;
    logic             err_no_clk;
    logic             err_over;

    modport master (
        output enable, meas_clk_in,
        input  clk_freq_enc, clock_frequency_enc, edge_count,
        input  meas_valid, locked, err_no_clk, err_over
    );

    modport slave (
        input  enable, meas_clk_in,
        output clk_freq_enc, clock_frequency_enc, edge_count,
        output meas_valid, locked, err_no_clk, err_over
    );
endinterface

// File: rtl/clk_freq_encoder.sv
// Counts rising edges of an asynchronous clock over a fixed gate window and
// encodes the result into one of four nominal frequencies.
`timescale 1ns/1ps
module clk_freq_encoder #(
    parameter int FIRST_FREQ  = 1,
    parameter int SECOND_FREQ = 2,
    parameter int THIRD_FREQ  = 4,
    parameter int FOURTH_FREQ = 8,
    parameter int REF_FREQ    = 32,
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 12
) (
    input logic               clk,
    input logic               rst,
    clk_freq_encoder_if.slave bus
);
    localparam int unsigned N0  = FIRST_FREQ  * GATE_CYCLES / REF_FREQ;
    localparam int unsigned N1  = SECOND_FREQ * GATE_CYCLES / REF_FREQ;
    localparam int unsigned N2  = THIRD_FREQ  * GATE_CYCLES / REF_FREQ;
    localparam int unsigned N3  = FOURTH_FREQ * GATE_CYCLES / REF_FREQ;
    localparam int unsigned TL  = N0 / 2;
    localparam int unsigned T01 = (N0 + N1) / 2;
    localparam int unsigned T12 = (N1 + N2) / 2;
    localparam int unsigned T23 = (N2 + N3) / 2;
    localparam int unsigned TH  = N3 + N3 / 2;

    localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, EVAL} state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, sync3, edge_p;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt, cnt_fin;
    logic             start, abort, win_done;
    logic [31:0]      c32;
    logic             cls_nc, cls_ov;
    logic [1:0]       cls_code;

    logic [1:0]       code_q;
    logic [3:0]       freq_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q, locked_q, nc_q, ov_q, have_prev;

    function automatic logic [3:0] freq_of(input logic [1:0] c);
        case (c)
            2'd0:    return 4'(FIRST_FREQ);
            2'd1:    return 4'(SECOND_FREQ);
            2'd2:    return 4'(THIRD_FREQ);
            default: return 4'(FOURTH_FREQ);
        endcase
    endfunction

    // Two-flop synchronizer, then a registered rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            sync1  <= bus.meas_clk_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_p <= sync2 & ~sync3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable) state_nxt = MEASURE;
            MEASURE: begin
                if (!bus.enable)             state_nxt = IDLE;
                else if (win_cnt == WIN_LAST) state_nxt = EVAL;
            end
            EVAL:    state_nxt = bus.enable ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start    = (state != MEASURE) && (state_nxt == MEASURE);
        abort    = (state == MEASURE) && !bus.enable;
        win_done = (state == MEASURE) && bus.enable && (win_cnt == WIN_LAST);
        cnt_fin  = (edge_p && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    end

    // Classification runs on the count including the last window cycle's edge,
    // so the result can be registered as the FSM enters EVAL.
    always_comb begin
        c32    = 32'(cnt_fin);
        cls_nc = c32 < TL;
        cls_ov = c32 >= TH;
        if (c32 < T01)      cls_code = 2'd0;
        else if (c32 < T12) cls_code = 2'd1;
        else if (c32 < T23) cls_code = 2'd2;
        else                cls_code = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst || start || abort) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (state == MEASURE) begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= cnt_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q    <= 2'd0;
            freq_q    <= 4'(FIRST_FREQ);
            count_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            nc_q      <= 1'b0;
            ov_q      <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (win_done) begin
                valid_q <= 1'b1;
                count_q <= cnt_fin;
                nc_q    <= cls_nc;
                ov_q    <= cls_ov;
                if (!cls_nc && !cls_ov) begin
                    code_q    <= cls_code;
                    freq_q    <= freq_of(cls_code);
                    have_prev <= 1'b1;
                    locked_q  <= have_prev && (cls_code == code_q);
                end else begin
                    locked_q  <= 1'b0;
                end
            end else if (abort) begin
                // An aborted window breaks the run of consecutive results.
                locked_q  <= 1'b0;
                have_prev <= 1'b0;
            end
        end
    end

    assign bus.clk_freq_enc        = code_q;
    assign bus.clock_frequency_enc = freq_q;
    assign bus.edge_count          = count_q;
    assign bus.meas_valid          = valid_q;
    assign bus.locked              = locked_q;
    assign bus.err_no_clk          = nc_q;
    assign bus.err_over            = ov_q;
endmodule

// File: tb/tb_clk_freq_encoder.sv
// Bench for clk_freq_encoder: directed window table, randomized periods against
// a count-band reference model, plus abort and mid-window reset sequences.
`timescale 1ns/1ps
module tb_clk_freq_encoder;
    localparam int G  = 1024;
    localparam int R  = 32;
    localparam int F0 = 1, F1 = 2, F2 = 4, F3 = 8;
    localparam int N0 = F0 * G / R, N1 = F1 * G / R, N2 = F2 * G / R, N3 = F3 * G / R;
    localparam int TL = N0 / 2, T01 = (N0 + N1) / 2, T12 = (N1 + N2) / 2;
    localparam int T23 = (N2 + N3) / 2, TH = N3 + N3 / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_freq_encoder_if #(.CNT_W(12)) bus ();
    clk_freq_encoder_if #(.CNT_W(8))  bus8 ();
    assign bus8.enable      = bus.enable;
    assign bus8.meas_clk_in = bus.meas_clk_in;

    clk_freq_encoder #(.FIRST_FREQ(F0), .SECOND_FREQ(F1), .THIRD_FREQ(F2), .FOURTH_FREQ(F3),
                       .REF_FREQ(R), .GATE_CYCLES(G), .CNT_W(12))
        dut (.clk(clk), .rst(rst), .bus(bus));
    clk_freq_encoder #(.FIRST_FREQ(F0), .SECOND_FREQ(F1), .THIRD_FREQ(F2), .FOURTH_FREQ(F3),
                       .REF_FREQ(R), .GATE_CYCLES(G), .CNT_W(8))
        dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int total = 0;
    int bad   = 0;

    // Square-wave generator: high for p/2 cycles, low for the rest; p=0 holds low.
    int gen_p  = 32;
    int last_p = 32;
    int ph     = 0;
    always @(negedge clk) begin
        if (gen_p != last_p) begin
            ph     = 0;
            last_p = gen_p;
        end
        if (gen_p == 0) bus.meas_clk_in = 1'b0;
        else begin
            bus.meas_clk_in = (ph < gen_p / 2);
            ph = (ph + 1) % gen_p;
        end
    end

    // Reference model: classes 0..3 are codes, 4 = no clock, 5 = over range.
    int m_code = 0, m_have = 0, m_lock = 0, m_nc = 0, m_ov = 0;
    int freq_tab[4] = '{F0, F1, F2, F3};

    function automatic int classify(input int c);
        if (c < TL)  return 4;
        if (c >= TH) return 5;
        if (c < T01) return 0;
        if (c < T12) return 1;
        if (c < T23) return 2;
        return 3;
    endfunction

    task automatic model_step(input int k);
        if (k < 4) begin
            m_lock = (m_have != 0 && k == m_code) ? 1 : 0;
            m_code = k;
            m_have = 1;
        end else m_lock = 0;
        m_nc = (k == 4) ? 1 : 0;
        m_ov = (k == 5) ? 1 : 0;
    endtask

    task automatic model_reset();
        m_code = 0; m_have = 0; m_lock = 0; m_nc = 0; m_ov = 0;
    endtask

    task automatic chk(input string nm, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_mv(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.meas_valid && cyc < 3000);
        if (!bus.meas_valid) begin
            total++;
            bad++;
            $display("FAIL meas_valid_timeout: got no pulse in %0d cycles, want one", cyc);
        end
    endtask

    task automatic chk_model(input int lo, input int hi, input int p);
        chk("edge_count", bus.edge_count, lo, hi);
        chk("clk_freq_enc", bus.clk_freq_enc, m_code, m_code);
        chk("clock_frequency_enc", bus.clock_frequency_enc, freq_tab[m_code], freq_tab[m_code]);
        chk("locked", bus.locked, m_lock, m_lock);
        chk("err_no_clk", bus.err_no_clk, m_nc, m_nc);
        chk("err_over", bus.err_over, m_ov, m_ov);
        if (lo >= 255)    chk("sat8_count", bus8.edge_count, 255, 255);
        else if (hi < 255) chk("cnt8_count", bus8.edge_count, lo, hi);
        if (p < 0) $display("unreachable");
    endtask

    task automatic run_win(input int p, input int lo, input int hi, output int cyc);
        gen_p = p;
        wait_mv(cyc);
        model_step(classify(lo));
        chk_model(lo, hi, p);
    endtask

    task automatic chk_reset_vals();
        chk("rst_code", bus.clk_freq_enc, 0, 0);
        chk("rst_freq", bus.clock_frequency_enc, F0, F0);
        chk("rst_count", bus.edge_count, 0, 0);
        chk("rst_valid", bus.meas_valid, 0, 0);
        chk("rst_locked", bus.locked, 0, 0);
        chk("rst_no_clk", bus.err_no_clk, 0, 0);
        chk("rst_over", bus.err_over, 0, 0);
    endtask

    task automatic idle_no_valid(input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.meas_valid) seen++;
        end
        chk("idle_meas_valid", seen, 0, 0);
    endtask

    typedef struct {
        int p, lo, hi, code, freq, lock, nc, ov;
    } vec_t;

    vec_t vecs[11];
    int   cyc;

    initial begin
        vecs = '{
            '{32,  31,  33, 0, 1, 0, 0, 0},
            '{32,  31,  33, 0, 1, 1, 0, 0},
            '{ 4, 253, 259, 3, 8, 0, 0, 0},
            '{ 4, 255, 257, 3, 8, 1, 0, 0},
            '{ 8, 125, 131, 2, 4, 0, 0, 0},
            '{ 8, 127, 129, 2, 4, 1, 0, 0},
            '{ 0,   0,   3, 2, 4, 0, 1, 0},
            '{ 0,   0,   0, 2, 4, 0, 1, 0},
            '{ 2, 509, 515, 2, 4, 0, 0, 1},
            '{16,  61,  67, 1, 2, 0, 0, 0},
            '{16,  63,  65, 1, 2, 1, 0, 0}
        };
        bus.enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;

        // Directed windows, back to back with enable held high.
        foreach (vecs[i]) begin
            gen_p = vecs[i].p;
            wait_mv(cyc);
            model_step(classify(vecs[i].lo));
            if (i == 0) chk("latency_first", cyc, G + 1, G + 1);
            else        chk("latency_next", cyc, G + 1, G + 1);
            chk("v_edge_count", bus.edge_count, vecs[i].lo, vecs[i].hi);
            chk("v_code", bus.clk_freq_enc, vecs[i].code, vecs[i].code);
            chk("v_freq", bus.clock_frequency_enc, vecs[i].freq, vecs[i].freq);
            chk("v_locked", bus.locked, vecs[i].lock, vecs[i].lock);
            chk("v_no_clk", bus.err_no_clk, vecs[i].nc, vecs[i].nc);
            chk("v_over", bus.err_over, vecs[i].ov, vecs[i].ov);
            if (vecs[i].p == 2) chk("sat8_no_wrap", bus8.edge_count, 255, 255);
        end

        // Random periods; bands that straddle a threshold are redrawn.
        for (int w = 0; w < 10; w++) begin
            int p = 0, lo = 0, hi = 3;
            for (int tries = 0; tries < 50; tries++) begin
                p  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 80));
                lo = (p == 0) ? 0 : G / p - 3;
                hi = (p == 0) ? 3 : (G + p - 1) / p + 3;
                if (lo < 0) lo = 0;
                if (classify(lo) == classify(hi)) break;
                p = 0; lo = 0; hi = 3;
            end
            run_win(p, lo, hi, cyc);
        end

        // Abort mid-window, then re-enable.
        run_win(16, 61, 67, cyc);
        run_win(16, 63, 65, cyc);
        repeat (499) @(negedge clk);
        bus.enable = 1'b0;
        m_lock = 0;
        m_have = 0;
        idle_no_valid(G + 80);
        chk("abort_locked", bus.locked, 0, 0);
        chk("abort_code_hold", bus.clk_freq_enc, m_code, m_code);
        chk("abort_freq_hold", bus.clock_frequency_enc, freq_tab[m_code], freq_tab[m_code]);
        chk("abort_count_hold", bus.edge_count, 63, 65);
        bus.enable = 1'b1;
        run_win(16, 63, 65, cyc);
        chk("latency_reenable", cyc, G + 1, G + 1);
        run_win(16, 63, 65, cyc);
        chk("locked_before_rst", bus.locked, 1, 1);

        // Reset mid-window while locked; enable stays high through reset.
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        model_reset();
        rst = 1'b0;
        bus.enable = 1'b0;
        idle_no_valid(G + 80);
        bus.enable = 1'b1;
        run_win(16, 63, 65, cyc);
        chk("latency_after_rst", cyc, G + 1, G + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_freq_encoder.md
CLK_FREQ_ENCODER -- requirements
Module: clk_freq_encoder

Interface
REQ-001 Parameters, one per line (name, default, meaning); the frequency parameters use the same units as REF_FREQ:
  FIRST_FREQ   1     frequency for code 2'b00
  SECOND_FREQ  2     frequency for code 2'b01
  THIRD_FREQ   4     frequency for code 2'b10
  FOURTH_FREQ  8     frequency for code 2'b11
  REF_FREQ     32    frequency of clk
  GATE_CYCLES  1024  clk cycles per measurement window
  CNT_W        12    edge-counter width
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk                  in   1      single system clock; all logic on rising edge
  rst                  in   1      reset, synchronous, active-high
  enable               in   1      1 = measure continuously, 0 = idle
  meas_clk_in          in   1      clock under test, asynchronous to clk, sampled as data
  clk_freq_enc         out  2      encoded frequency select, 00..11
  clock_frequency_enc  out  4      frequency value matching clk_freq_enc
  edge_count           out  CNT_W  raw edge count of the last completed window
  meas_valid           out  1      one-cycle pulse when a window result is published
  locked               out  1      two consecutive windows gave the same valid code
  err_no_clk           out  1      last window count below the low threshold
  err_over             out  1      last window count at or above the high threshold

Function
REQ-003 The block SHALL pass meas_clk_in through a 2-flop synchronizer followed by a registered rising-edge detector, giving a one-cycle edge pulse 3 clk cycles after the input edge.
REQ-004 The block SHALL support meas_clk_in frequencies strictly below REF_FREQ/2.
REQ-005 The FSM SHALL have three states:
  - IDLE: moves to MEASURE when enable=1.
  - MEASURE: window counter runs 0..GATE_CYCLES-1; then moves to EVAL.
  - EVAL: lasts exactly 1 cycle; then moves to MEASURE if enable=1, else to IDLE.
REQ-006 On entering MEASURE, the window counter and the edge counter SHALL both clear to 0.
REQ-007 The edge counter SHALL increment on each edge pulse seen in MEASURE, including the cycle in which the window counter equals GATE_CYCLES-1.
REQ-008 Edge pulses seen in EVAL or IDLE SHALL be discarded.
REQ-009 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-010 Expected counts SHALL be computed at elaboration as N_k = FREQ_k*GATE_CYCLES/REF_FREQ, using integer division.
REQ-011 Thresholds SHALL be computed at elaboration as follows:
  - TL = N0/2
  - T01 = (N0+N1)/2
  - T12 = (N1+N2)/2
  - T23 = (N2+N3)/2
  - TH = N3 + N3/2
REQ-012 In EVAL, the count C SHALL be classified as:
  - C<TL: err_no_clk=1
  - C>=TH: err_over=1
  - [TL,T01): code 00
  - [T01,T12): code 01
  - [T12,T23): code 10
  - [T23,TH): code 11
REQ-013 In EVAL, the block SHALL register edge_count=C, update both error flags, and pulse meas_valid for exactly the EVAL cycle.
REQ-014 clk_freq_enc and clock_frequency_enc SHALL update only on an error-free window.
REQ-015 On an errored window, clk_freq_enc and clock_frequency_enc SHALL hold their previous values.
REQ-016 clock_frequency_enc SHALL equal the FREQ parameter of the published code.
REQ-017 locked SHALL set in EVAL when the window is error-free and its code equals the previous error-free window's code.
REQ-018 locked SHALL clear in EVAL on an error or a code mismatch.
REQ-019 If enable goes to 0 during MEASURE, the block SHALL abort to IDLE on the next cycle, clear both counters and locked, and produce no meas_valid.
REQ-020 If enable goes to 0 during MEASURE, the block SHALL hold the other outputs.
REQ-021 If enable goes to 0 during EVAL, the EVAL cycle SHALL complete normally.
REQ-022 Latency: meas_valid SHALL occur GATE_CYCLES+1 cycles after the cycle in which the FSM leaves IDLE or EVAL.

Reset
REQ-023 When rst=1 at a clk edge, the FSM SHALL go to IDLE and all counters and synchronizer flops SHALL clear.
REQ-024 Output reset values SHALL be: clk_freq_enc=00, clock_frequency_enc=FIRST_FREQ, edge_count=0, meas_valid=0, locked=0, err_no_clk=0, err_over=0.
REQ-025 rst SHALL take priority over enable in every state, including mid-window.

Verification
REQ-026 The bench SHALL use default parameters, with thresholds TL=16, T01=48, T12=96, T23=192, TH=384, and SHALL cover these directed scenarios:
  - meas period = 32 clk cycles, enable=1 -> edge_count 32±1, clk_freq_enc=00, clock_frequency_enc=1, meas_valid 1025 cycles after leaving IDLE; locked=1 after the 2nd window.
  - meas period = 4 clk cycles -> edge_count 256±1, code 11, clock_frequency_enc=8; switch to period 8 -> next window code 10, locked=0, third window locked=1.
  - meas_clk_in held at 0 -> edge_count=0, err_no_clk=1, clk_freq_enc holds its prior value, locked=0.
  - meas period = 2 clk cycles (REF_FREQ/2; above the supported range, REQ-004) -> err_over=1, code unchanged; with CNT_W=8 override the count saturates at 255 with no wrap.
  - enable dropped at window cycle 500 -> no meas_valid, locked=0, FSM in IDLE; re-enable -> a full new window with the count restarting at 0.
  - rst pulsed mid-window while locked -> all outputs take their REQ-024 values on the next cycle; measurement restarts only after enable=1.
